// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter/mux: each master owns a one-entry address-phase hold
// register so a losing or stalled transfer is replayed later instead of dropped.
module ahb_lite_arbiter_2m #(
  parameter bit FIXED_PRIO  = 1'b0,
  parameter bit HOLD_NONSEQ = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HRESP,
  output logic        S_MASTER
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  // Handshake: an address phase presented downstream completes on the HCLK edge
  // where S_HREADYOUT = 1; a master's own phase completes only where its Mx_HREADY = 1.

  logic [1:0]  pend_q, pend_d;
  logic [31:0] hold_addr_q  [2];
  logic [31:0] hold_addr_d  [2];
  logic [1:0]  hold_trans_q [2];
  logic [1:0]  hold_trans_d [2];
  logic        hold_write_q [2];
  logic        hold_write_d [2];
  logic [2:0]  hold_size_q  [2];
  logic [2:0]  hold_size_d  [2];
  logic        own_vld_q, own_vld_d;
  logic        own_q, own_d;
  logic        rr_q, rr_d;
  logic        lock_q, lock_d;
  logic        sel_q, sel_d;

  logic [31:0] live_addr  [2];
  logic [1:0]  live_trans [2];
  logic        live_write [2];
  logic [2:0]  live_size  [2];
  logic [1:0]  hready;
  logic [1:0]  live_req;
  logic [1:0]  req;
  logic        any_req;
  logic        sel;
  logic        los;
  logic [31:0] drv_addr;
  logic [1:0]  drv_trans;
  logic        drv_write;
  logic [2:0]  drv_size;

  assign live_addr[0]  = M0_HADDR;
  assign live_addr[1]  = M1_HADDR;
  assign live_trans[0] = M0_HTRANS;
  assign live_trans[1] = M1_HTRANS;
  assign live_write[0] = M0_HWRITE;
  assign live_write[1] = M1_HWRITE;
  assign live_size[0]  = M0_HSIZE;
  assign live_size[1]  = M1_HSIZE;

  // The data-phase owner sees the slave's ready even if it also has a stalled hold entry.
  always_comb begin
    hready[0] = (own_vld_q && !own_q) ? S_HREADYOUT : !pend_q[0];
    hready[1] = (own_vld_q &&  own_q) ? S_HREADYOUT : !pend_q[1];
    for (int i = 0; i < 2; i++) begin
      live_req[i] = live_trans[i][1] && hready[i] && !pend_q[i];
      req[i]      = pend_q[i] || live_req[i];
    end
    any_req = req[0] || req[1];
  end

  always_comb begin
    sel = sel_q;
    if (lock_q) begin
      sel = sel_q;
    end else if (req[0] && !req[1]) begin
      sel = 1'b0;
    end else if (req[1] && !req[0]) begin
      sel = 1'b1;
    end else if (req[0] && req[1]) begin
      sel = FIXED_PRIO ? 1'b0 : !rr_q;
    end
    los = !sel;
  end

  always_comb begin
    drv_addr  = live_addr[sel];
    drv_trans = live_trans[sel];
    drv_write = live_write[sel];
    drv_size  = live_size[sel];
    if (pend_q[sel]) begin
      drv_addr  = hold_addr_q[sel];
      drv_trans = hold_trans_q[sel];
      drv_write = hold_write_q[sel];
      drv_size  = hold_size_q[sel];
    end
    if (!any_req) begin
      drv_trans = TR_IDLE;
    end
  end

  always_comb begin
    pend_d       = pend_q;
    hold_addr_d  = hold_addr_q;
    hold_trans_d = hold_trans_q;
    hold_write_d = hold_write_q;
    hold_size_d  = hold_size_q;
    own_vld_d    = own_vld_q;
    own_d        = own_q;
    rr_d         = rr_q;
    lock_d       = lock_q;
    sel_d        = sel;
    if (any_req && S_HREADYOUT) begin
      own_vld_d    = 1'b1;
      own_d        = sel;
      pend_d[sel]  = 1'b0;
      rr_d         = sel;
      lock_d       = 1'b0;
    end else if (S_HREADYOUT) begin
      own_vld_d    = 1'b0;
    end else if (any_req) begin
      // Stalled: the driven beat is frozen verbatim so the slave sees stable control.
      pend_d[sel]       = 1'b1;
      hold_addr_d[sel]  = drv_addr;
      hold_trans_d[sel] = drv_trans;
      hold_write_d[sel] = drv_write;
      hold_size_d[sel]  = drv_size;
      lock_d            = 1'b1;
    end
    if (live_req[los]) begin
      pend_d[los]       = 1'b1;
      hold_addr_d[los]  = live_addr[los];
      hold_trans_d[los] = HOLD_NONSEQ ? TR_NONSEQ : live_trans[los];
      hold_write_d[los] = live_write[los];
      hold_size_d[los]  = live_size[los];
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend_q    <= 2'b00;
      own_vld_q <= 1'b0;
      own_q     <= 1'b0;
      rr_q      <= 1'b1;
      lock_q    <= 1'b0;
      sel_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        hold_addr_q[i]  <= 32'h0;
        hold_trans_q[i] <= TR_IDLE;
        hold_write_q[i] <= 1'b0;
        hold_size_q[i]  <= 3'b000;
      end
    end else begin
      pend_q       <= pend_d;
      own_vld_q    <= own_vld_d;
      own_q        <= own_d;
      rr_q         <= rr_d;
      lock_q       <= lock_d;
      sel_q        <= sel_d;
      hold_addr_q  <= hold_addr_d;
      hold_trans_q <= hold_trans_d;
      hold_write_q <= hold_write_d;
      hold_size_q  <= hold_size_d;
    end
  end

  assign S_HADDR   = drv_addr;
  assign S_HTRANS  = drv_trans;
  assign S_HWRITE  = drv_write;
  assign S_HSIZE   = drv_size;
  assign S_MASTER  = any_req ? sel : 1'b0;
  assign S_HWDATA  = !own_vld_q ? 32'h0 : (own_q ? M1_HWDATA : M0_HWDATA);
  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HREADY = hready[0];
  assign M1_HREADY = hready[1];
  assign M0_HRESP  = own_vld_q && !own_q && S_HRESP;
  assign M1_HRESP  = own_vld_q &&  own_q && S_HRESP;

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed bench for ahb_lite_arbiter_2m: a round-robin instance and a fixed-priority
// instance share all inputs; checks are taken on the falling edge.
module tb_ahb_lite_arbiter_2m;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] M0_HADDR = '0, M1_HADDR = '0, M0_HWDATA = '0, M1_HWDATA = '0;
  logic [1:0]  M0_HTRANS = '0, M1_HTRANS = '0;
  logic        M0_HWRITE = 1'b0, M1_HWRITE = 1'b0;
  logic [2:0]  M0_HSIZE = 3'b010, M1_HSIZE = 3'b010;
  logic        S_HREADYOUT = 1'b1, S_HRESP = 1'b0;
  logic [31:0] S_HRDATA = '0;

  logic [31:0] M0_HRDATA, M1_HRDATA, S_HADDR, S_HWDATA;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP, S_HWRITE, S_MASTER;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE;

  logic [31:0] fp_M0_HRDATA, fp_M1_HRDATA, fp_S_HADDR, fp_S_HWDATA;
  logic        fp_M0_HREADY, fp_M1_HREADY, fp_M0_HRESP, fp_M1_HRESP, fp_S_HWRITE, fp_S_MASTER;
  logic [1:0]  fp_S_HTRANS;
  logic [2:0]  fp_S_HSIZE;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_arbiter_2m #(.FIXED_PRIO(1'b0), .HOLD_NONSEQ(1'b1)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HWDATA(S_HWDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP),
    .S_MASTER(S_MASTER)
  );

  ahb_lite_arbiter_2m #(.FIXED_PRIO(1'b1), .HOLD_NONSEQ(1'b1)) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(fp_M0_HRDATA), .M0_HREADY(fp_M0_HREADY), .M0_HRESP(fp_M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(fp_M1_HRDATA), .M1_HREADY(fp_M1_HREADY), .M1_HRESP(fp_M1_HRESP),
    .S_HADDR(fp_S_HADDR), .S_HTRANS(fp_S_HTRANS), .S_HWRITE(fp_S_HWRITE), .S_HSIZE(fp_S_HSIZE),
    .S_HWDATA(fp_S_HWDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP),
    .S_MASTER(fp_S_MASTER)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_masters();
    M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
    M0_HWRITE = 1'b0;  M1_HWRITE = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    idle_masters();
    S_HREADYOUT = 1'b1;
    S_HRESP     = 1'b0;
    HRESETn     = 1'b0;
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  // Two bus masters that advance only on a sampled HREADY; grants are logged per beat.
  task automatic run_contention(input bit use_fp);
    int cnt0 = 0, cnt1 = 0, grants = 0;
    logic rdy0, rdy1, gm;
    logic [1:0] tr;
    for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
      M0_HTRANS = (cnt0 < 4) ? 2'b10 : 2'b00;
      M0_HADDR  = 32'h1000 + 32'(cnt0 * 4);
      M1_HTRANS = (cnt1 < 4) ? 2'b10 : 2'b00;
      M1_HADDR  = 32'h2000 + 32'(cnt1 * 4);
      @(negedge HCLK);
      rdy0 = use_fp ? fp_M0_HREADY : M0_HREADY;
      rdy1 = use_fp ? fp_M1_HREADY : M1_HREADY;
      tr   = use_fp ? fp_S_HTRANS  : S_HTRANS;
      gm   = use_fp ? fp_S_MASTER  : S_MASTER;
      if (tr[1] && S_HREADYOUT) begin
        if (use_fp) check_eq($sformatf("fp_grant%0d", grants), {31'h0, gm}, (grants < 4) ? 32'd0 : 32'd1);
        else        check_eq($sformatf("rr_grant%0d", grants), {31'h0, gm}, 32'(grants % 2));
        grants++;
      end
      next_cycle();
      if (rdy0 && cnt0 < 4) cnt0++;
      if (rdy1 && cnt1 < 4) cnt1++;
    end
    check_eq(use_fp ? "fp_grant_count" : "rr_grant_count", 32'(grants), 32'd8);
    idle_masters();
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge HCLK);
    check_eq("rst_htrans", {30'h0, S_HTRANS}, 32'd0);
    check_eq("rst_m0_hready", {31'h0, M0_HREADY}, 32'd1);
    check_eq("rst_m1_hready", {31'h0, M1_HREADY}, 32'd1);
    check_eq("rst_m0_hresp", {31'h0, M0_HRESP}, 32'd0);
    check_eq("rst_s_master", {31'h0, S_MASTER}, 32'd0);

    // M0 alone, zero-wait read: pass-through in the same cycle
    next_cycle();
    M0_HADDR = 32'h100; M0_HTRANS = 2'b10;
    @(negedge HCLK);
    check_eq("solo_haddr", S_HADDR, 32'h100);
    check_eq("solo_htrans", {30'h0, S_HTRANS}, 32'd2);
    check_eq("solo_m0_hready", {31'h0, M0_HREADY}, 32'd1);
    check_eq("solo_m1_hready", {31'h0, M1_HREADY}, 32'd1);
    next_cycle();
    idle_masters(); S_HRDATA = 32'hDEADBEEF;
    @(negedge HCLK);
    check_eq("solo_data_hready", {31'h0, M0_HREADY}, 32'd1);
    check_eq("solo_hrdata", M0_HRDATA, 32'hDEADBEEF);
    check_eq("solo_hrdata_m1", M1_HRDATA, 32'hDEADBEEF);

    // Simultaneous NONSEQ: M0 read 0x10 first, M1 write 0x20 replayed next
    do_reset();
    M0_HADDR = 32'h10; M0_HTRANS = 2'b10;
    M1_HADDR = 32'h20; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1;
    @(negedge HCLK);
    check_eq("tie_a_haddr", S_HADDR, 32'h10);
    check_eq("tie_a_master", {31'h0, S_MASTER}, 32'd0);
    next_cycle();
    idle_masters(); M1_HWDATA = 32'hA5A5A5A5;
    @(negedge HCLK);
    check_eq("tie_b_m1_hready", {31'h0, M1_HREADY}, 32'd0);
    check_eq("tie_b_haddr", S_HADDR, 32'h20);
    check_eq("tie_b_htrans", {30'h0, S_HTRANS}, 32'd2);
    check_eq("tie_b_hwrite", {31'h0, S_HWRITE}, 32'd1);
    check_eq("tie_b_master", {31'h0, S_MASTER}, 32'd1);
    next_cycle();
    @(negedge HCLK);
    check_eq("tie_c_hwdata", S_HWDATA, 32'hA5A5A5A5);
    check_eq("tie_c_m1_hready", {31'h0, M1_HREADY}, 32'd1);

    // A losing SEQ beat is replayed as NONSEQ
    do_reset();
    M0_HADDR = 32'h70; M0_HTRANS = 2'b10;
    M1_HADDR = 32'h84; M1_HTRANS = 2'b11;
    next_cycle();
    idle_masters();
    @(negedge HCLK);
    check_eq("seq_replay_haddr", S_HADDR, 32'h84);
    check_eq("seq_replay_htrans", {30'h0, S_HTRANS}, 32'd2);

    // Continuous contention, round-robin then fixed priority
    do_reset();
    run_contention(1'b0);
    do_reset();
    run_contention(1'b1);

    // Slave stall for 3 cycles on an M1 address phase while M0 also requests
    do_reset();
    M1_HADDR = 32'h40; M1_HTRANS = 2'b10; S_HREADYOUT = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        M1_HTRANS = 2'b00;
        M0_HADDR = 32'h50; M0_HTRANS = 2'b10;
      end
      if (c == 2) M0_HTRANS = 2'b00;
      if (c == 3) S_HREADYOUT = 1'b1;
      @(negedge HCLK);
      check_eq($sformatf("stall%0d_haddr", c), S_HADDR, 32'h40);
      check_eq($sformatf("stall%0d_htrans", c), {30'h0, S_HTRANS}, 32'd2);
      check_eq($sformatf("stall%0d_master", c), {31'h0, S_MASTER}, 32'd1);
      if (c >= 2) check_eq($sformatf("stall%0d_m0_hready", c), {31'h0, M0_HREADY}, 32'd0);
      next_cycle();
    end
    @(negedge HCLK);
    check_eq("stall_after_haddr", S_HADDR, 32'h50);
    check_eq("stall_after_master", {31'h0, S_MASTER}, 32'd0);
    check_eq("stall_after_m1_hready", {31'h0, M1_HREADY}, 32'd1);
    next_cycle();
    idle_masters();

    // Two-cycle ERROR on an M0 data phase
    do_reset();
    M0_HADDR = 32'h60; M0_HTRANS = 2'b10;
    next_cycle();
    idle_masters(); S_HRESP = 1'b1; S_HREADYOUT = 1'b0;
    @(negedge HCLK);
    check_eq("err1_m0_hresp", {31'h0, M0_HRESP}, 32'd1);
    check_eq("err1_m1_hresp", {31'h0, M1_HRESP}, 32'd0);
    check_eq("err1_m0_hready", {31'h0, M0_HREADY}, 32'd0);
    next_cycle();
    S_HREADYOUT = 1'b1;
    @(negedge HCLK);
    check_eq("err2_m0_hresp", {31'h0, M0_HRESP}, 32'd1);
    check_eq("err2_m1_hresp", {31'h0, M1_HRESP}, 32'd0);
    check_eq("err2_m0_hready", {31'h0, M0_HREADY}, 32'd1);
    next_cycle();
    S_HRESP = 1'b0;
    @(negedge HCLK);
    check_eq("err_done_m0_hresp", {31'h0, M0_HRESP}, 32'd0);

    // Reset while M1 is pending abandons the held transfer
    do_reset();
    M0_HADDR = 32'h10; M0_HTRANS = 2'b10;
    M1_HADDR = 32'h20; M1_HTRANS = 2'b10;
    next_cycle();
    idle_masters(); HRESETn = 1'b0;
    @(negedge HCLK);
    check_eq("prst_m1_hready", {31'h0, M1_HREADY}, 32'd0);
    next_cycle();
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_eq("prst_htrans", {30'h0, S_HTRANS}, 32'd0);
    check_eq("prst_m0_hready", {31'h0, M0_HREADY}, 32'd1);
    check_eq("prst_m1_hready_after", {31'h0, M1_HREADY}, 32'd1);
    check_eq("prst_s_master", {31'h0, S_MASTER}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arbiter_2m.md
Name: ahb_lite_arbiter_2m

Overview:
- Two-master AHB-Lite arbiter and bus multiplexer between the Cortex-M0 (M0) and a second bus master such as a DMA engine (M1). It drives a single downstream AHB-Lite slave port that feeds the RAM and console decode.
- Each master gets a one-entry address-phase hold register, so a master that loses arbitration sees wait states. It does not lose its transfer.
- Uncontested transfers pass through with zero added latency.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin between masters; 1 = M0 always wins a tie.
- HOLD_NONSEQ, 1: 1 = a transfer replayed from a hold register is driven downstream as NONSEQ (the burst is broken); 0 = the original HTRANS is replayed.

Ports:
- HCLK  in  1  bus clock, rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- Mx_HADDR  in  32  master x address (x = 0, 1; one port per master).
- Mx_HTRANS  in  2  master x transfer type.
- Mx_HWRITE  in  1  master x write.
- Mx_HSIZE  in  3  master x size.
- Mx_HWDATA  in  32  master x write data.
- Mx_HRDATA  out  32  read data to master x.
- Mx_HREADY  out  1  ready to master x.
- Mx_HRESP  out  1  error response to master x.
- S_HADDR  out  32  downstream address.
- S_HTRANS  out  2  downstream transfer type.
- S_HWRITE  out  1  downstream write.
- S_HSIZE  out  3  downstream size.
- S_HWDATA  out  32  downstream write data.
- S_HREADYOUT  in  1  downstream ready.
- S_HRDATA  in  32  downstream read data.
- S_HRESP  in  1  downstream error.
- S_MASTER  out  1  master owning the current address phase (0 or 1; debug and decode).

Behaviour:
- Reset (HRESETn low at a rising HCLK edge):
  - pend0 = pend1 = 0; data-phase owner = NONE; round-robin pointer = M1 (so M0 wins the first tie); lock = 0.
  - Outputs: S_HTRANS = IDLE; Mx_HREADY = 1; Mx_HRESP = 0; S_MASTER = 0.
  - Reset mid-transfer abandons every held and in-flight transfer; nothing is replayed.
- Master request: reqx = pendx, or (Mx_HTRANS[1] and Mx_HREADY = 1 this cycle).
  - IDLE and BUSY are never requests.
  - While Mx_HREADY = 0, the master's live bus is not sampled.
- Selection (combinational):
  - If lock = 1, keep the previous selection.
  - Otherwise: a single requester wins. On a tie, the master not granted last wins; with FIXED_PRIO = 1, M0 wins.
- Downstream address phase:
  - Driven from the hold register if pend_sel = 1, else from the live master inputs.
  - S_HTRANS = IDLE when there is no request.
- Acceptance: the selected transfer is accepted when S_HREADYOUT = 1. Then:
  - owner <= sel; pend_sel <= 0; pointer <= sel; lock <= 0.
- Not accepted (S_HREADYOUT = 0 with S_HTRANS non-IDLE):
  - The driven transfer is copied into its hold register (pend <= 1) and lock <= 1.
  - The downstream address/control therefore stays bit-identical until accepted.
- Losing live request: captured into its hold register (pend <= 1) on the same edge, fields HADDR/HWRITE/HSIZE/HTRANS.
- Mx_HREADY:
  - If x = owner: follows S_HREADYOUT.
  - Else if pendx = 1: 0.
  - Else: 1.
  - A pending master's data phase completes only after its transfer is accepted and its own data phase ends.
- Data phase:
  - S_HWDATA = HWDATA of the owner (0 when owner = NONE).
  - S_HRDATA is broadcast to both masters.
  - S_HRESP goes to the owner only; the non-owner sees 0.
  - The two-cycle ERROR response passes through unchanged. A pending transfer of the other master is unaffected.
  - A master receiving ERROR may drive IDLE; its pending entry is cleared only if it was never accepted and the master had HREADY low. That case does not occur, because an in-flight data phase and a hold entry of the same master are exclusive.
- Throughput and latency:
  - Back-to-back contested requests alternate M0, M1, M0, ... under round-robin.
  - Each loser sees exactly one extra wait state per intervening transfer at zero-wait-state slaves.

Test Plan:
- M0 only, word read at 0x00000100 with slave zero-wait → S_HADDR = 0x100 in the same cycle; M0_HREADY never low; M1_HREADY = 1.
- M0 and M1 NONSEQ in the same cycle (M0 reads 0x10, M1 writes 0xA5A5A5A5 to 0x20) → M0 is driven first; M1_HREADY = 0 for one cycle; next cycle S_HADDR = 0x20 with S_HTRANS = NONSEQ; S_HWDATA = 0xA5A5A5A5 in the following cycle.
- Continuous contention for 8 transfers with FIXED_PRIO = 0 → grant sequence 0,1,0,1,0,1,0,1; with FIXED_PRIO = 1 → M0 on all 4 of its transfers before any M1.
- S_HREADYOUT held low for 3 cycles during an M1 address phase while M0 also requests → S_HADDR/S_HTRANS stable for all 3 cycles; M1 is accepted first, then M0.
- S_HRESP = 1 for 2 cycles during an M0 data phase → M0_HRESP = 1 for 2 cycles; M1_HRESP stays 0.
- HRESETn low for one edge while M1 is pending → pend1 = 0; S_HTRANS = IDLE; both Mx_HREADY = 1 the next cycle.
